// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: multi-cycle load-use stalls, mul/div EX hold,
// and taken-branch flush, with a saturating count of front-end stall cycles.
module hazard_control_unit #(
  parameter int REG_W         = 5,
  parameter int LOAD_LATENCY  = 1,
  parameter int MULDIV_CYCLES = 4,
  parameter int IGNORE_X0     = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_MulDiv,
  input  logic [REG_W-1:0] IFID_rs1,
  input  logic [REG_W-1:0] IFID_rs2,
  input  logic             IFID_rs1_used,
  input  logic             IFID_rs2_used,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_mux_out,
  output logic             EXMEM_mux_out,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MAX_LAT = (LOAD_LATENCY > MULDIV_CYCLES) ? LOAD_LATENCY : MULDIV_CYCLES;
  localparam int CW      = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);
  localparam int LOAD_INIT_I = (LOAD_LATENCY >= 2) ? LOAD_LATENCY - 2 : 0;
  localparam int MD_INIT_I   = (MULDIV_CYCLES >= 2) ? MULDIV_CYCLES - 2 : 0;
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_INIT_I);
  localparam logic [CW-1:0] MD_INIT   = CW'(MD_INIT_I);

  typedef enum logic [1:0] {IDLE, LOAD_STALL, MD_BUSY} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_count_reg;
  logic             rd_valid, hit;

  assign rd_valid = (IDEX_rd != '0) || (IGNORE_X0 == 0);
  assign hit = IDEX_MemRead && rd_valid &&
               ((IFID_rs1_used && (IFID_rs1 == IDEX_rd)) ||
                (IFID_rs2_used && (IFID_rs2 == IDEX_rd)));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    PCWrite       = 1'b1;
    IFID_Write    = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Write    = 1'b1;
    IDEX_mux_out  = 1'b1;
    EXMEM_mux_out = 1'b1;
    busy          = 1'b0;
    if (!reset) begin
      busy = (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (branch_taken) begin
            IFID_Flush   = 1'b1;
            IDEX_mux_out = 1'b0;
          end else if (IDEX_MulDiv) begin
            PCWrite       = 1'b0;
            IFID_Write    = 1'b0;
            IDEX_Write    = 1'b0;
            EXMEM_mux_out = 1'b0;
            cnt_next      = MD_INIT;
            state_next    = MD_BUSY;
          end else if (hit) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_mux_out = 1'b0;
            // With a single-cycle latency the bubble now entering EX clears the hit.
            if (LOAD_LATENCY > 1) begin
              cnt_next   = LOAD_INIT;
              state_next = LOAD_STALL;
            end
          end
        end
        LOAD_STALL: begin
          PCWrite      = 1'b0;
          IFID_Write   = 1'b0;
          IDEX_mux_out = 1'b0;
          if (cnt_reg == '0) state_next = IDLE;
          else               cnt_next   = cnt_reg - CW'(1);
        end
        MD_BUSY: begin
          // Final cycle passes everything so the completed result leaves EX.
          if (cnt_reg != '0) begin
            PCWrite       = 1'b0;
            IFID_Write    = 1'b0;
            IDEX_Write    = 1'b0;
            EXMEM_mux_out = 1'b0;
            cnt_next      = cnt_reg - CW'(1);
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!PCWrite && (stall_count_reg != {CNT_W{1'b1}}))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two differently-parameterised controllers share random
// stimulus; a time-based reference model predicts each cycle's outputs.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IDEX_rd, IFID_rs1, IFID_rs2;
  logic       IDEX_MemRead, IDEX_MulDiv, IFID_rs1_used, IFID_rs2_used, branch_taken;

  logic       pc_a, ifw_a, fl_a, idw_a, idm_a, exm_a, busy_a;
  logic [15:0] cnt_a;
  logic       pc_b, ifw_b, fl_b, idw_b, idm_b, exm_b, busy_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(1), .MULDIV_CYCLES(4), .IGNORE_X0(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MulDiv(IDEX_MulDiv), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_rs1_used(IFID_rs1_used), .IFID_rs2_used(IFID_rs2_used), .branch_taken(branch_taken),
    .PCWrite(pc_a), .IFID_Write(ifw_a), .IFID_Flush(fl_a), .IDEX_Write(idw_a),
    .IDEX_mux_out(idm_a), .EXMEM_mux_out(exm_a), .busy(busy_a), .stall_count(cnt_a));

  hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(3), .MULDIV_CYCLES(8), .IGNORE_X0(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MulDiv(IDEX_MulDiv), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_rs1_used(IFID_rs1_used), .IFID_rs2_used(IFID_rs2_used), .branch_taken(branch_taken),
    .PCWrite(pc_b), .IFID_Write(ifw_b), .IFID_Flush(fl_b), .IDEX_Write(idw_b),
    .IDEX_mux_out(idm_b), .EXMEM_mux_out(exm_b), .busy(busy_b), .stall_count(cnt_b));

  typedef struct {
    int         cyc;
    logic [6:0] f [2];
    int         c [2];
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   done = 0;

  // Reference state: 0 = free, 1 = load stall in progress, 2 = mul/div in EX.
  int mode [2] = '{0, 0};
  int t0   [2] = '{0, 0};
  int scnt [2] = '{0, 0};

  function automatic int p_ll(int k);  return (k == 0) ? 1 : 3;  endfunction
  function automatic int p_md(int k);  return (k == 0) ? 4 : 8;  endfunction
  function automatic int p_max(int k); return (k == 0) ? 65535 : 7; endfunction

  task automatic drive(input logic r, input logic [4:0] rd, input logic mr, input logic md,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic br);
    exp_t e;
    logic hit;
    @(posedge clk);
    #1;
    reset = r; IDEX_rd = rd; IDEX_MemRead = mr; IDEX_MulDiv = md;
    IFID_rs1 = rs1; IFID_rs2 = rs2; IFID_rs1_used = u1; IFID_rs2_used = u2; branch_taken = br;
    hit = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.cyc = cyc;
    for (int k = 0; k < 2; k++) begin
      logic pc, ifw, fl, idw, idm, exm, bz;
      int el;
      pc = 1; ifw = 1; fl = 0; idw = 1; idm = 1; exm = 1; bz = 0;
      el = cyc - t0[k];
      if (r) begin
        mode[k] = 0;
      end else if (mode[k] == 0) begin
        if (br) begin
          fl = 1; idm = 0;
        end else if (md) begin
          pc = 0; ifw = 0; idw = 0; exm = 0;
          mode[k] = 2; t0[k] = cyc;
        end else if (hit) begin
          pc = 0; ifw = 0; idm = 0;
          if (p_ll(k) > 1) begin mode[k] = 1; t0[k] = cyc; end
        end
      end else if (mode[k] == 1) begin
        bz = 1; pc = 0; ifw = 0; idm = 0;
        if (el >= p_ll(k) - 1) mode[k] = 0;
      end else begin
        bz = 1;
        if (el < p_md(k) - 1) begin
          pc = 0; ifw = 0; idw = 0; exm = 0;
        end else begin
          mode[k] = 0;
        end
      end
      e.f[k] = {pc, ifw, fl, idw, idm, exm, bz};
      e.c[k] = scnt[k];
      if (r)                             scnt[k] = 0;
      else if (!pc && scnt[k] < p_max(k)) scnt[k] = scnt[k] + 1;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        logic [6:0] fa, fb;
        e  = exp_q.pop_front();
        fa = {pc_a, ifw_a, fl_a, idw_a, idm_a, exm_a, busy_a};
        fb = {pc_b, ifw_b, fl_b, idw_b, idm_b, exm_b, busy_b};
        checks += 4;
        if (fa !== e.f[0]) begin errors++; $display("FAIL ctrl_a cyc=%0d got=%b want=%b", e.cyc, fa, e.f[0]); end
        if (int'(cnt_a) != e.c[0]) begin errors++; $display("FAIL count_a cyc=%0d got=%0d want=%0d", e.cyc, cnt_a, e.c[0]); end
        if (fb !== e.f[1]) begin errors++; $display("FAIL ctrl_b cyc=%0d got=%b want=%b", e.cyc, fb, e.f[1]); end
        if (int'(cnt_b) != e.c[1]) begin errors++; $display("FAIL count_b cyc=%0d got=%0d want=%0d", e.cyc, cnt_b, e.c[1]); end
        $display("cyc %0d rst=%b a:%b/%0d b:%b/%0d", e.cyc, reset, fa, cnt_a, fb, cnt_b);
      end
    end
  end

  initial begin
    reset = 1; IDEX_rd = 0; IDEX_MemRead = 0; IDEX_MulDiv = 0; IFID_rs1 = 0; IFID_rs2 = 0;
    IFID_rs1_used = 0; IFID_rs2_used = 0; branch_taken = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 1, 5, 5, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw x5 followed by a reader of x5, then the hazard goes away
    drive(0, 5, 1, 0, 5, 0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on rs2=x7, held so the longer latency is exercised
    repeat (3) drive(0, 7, 1, 0, 1, 7, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // rs2 not used, and rd=x0: no stall
    drive(0, 7, 1, 0, 1, 7, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 1, 0);
    // branch beats a simultaneous load-use hit
    drive(0, 5, 1, 0, 5, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mul/div held high
    repeat (9) drive(0, 3, 0, 1, 0, 0, 0, 0, 0);
    // reset mid mul/div
    repeat (3) drive(0, 3, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back load-use stalls drive the narrow counter into saturation
    repeat (12) drive(0, 2, 1, 0, 2, 2, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 2,
            5'($urandom_range(0, 3)), $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 8,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 10);
    end
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC-V core. It handles three cases. Load-use stalls can last more than one cycle (configurable memory latency). Multi-cycle mul/div instructions hold the EX stage. A taken branch resolved in EX flushes IF/ID and ID/EX. It drives the PC, IF/ID, ID/EX and EX/MEM write/bubble controls and exposes a saturating stall-cycle counter.

Parameters:
REG_W, 5, register address width
LOAD_LATENCY, 1, load-use stall cycles; legal 1..15
MULDIV_CYCLES, 4, cycles a mul/div occupies EX; legal 2..16
IGNORE_X0, 1, if 1 a destination of x0 never creates a hazard
CNT_W, 16, stall_count width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
IDEX_rd  in  REG_W  destination reg of instruction in EX
IDEX_MemRead  in  1  EX instruction is a load
IDEX_MulDiv  in  1  EX instruction is mul/div
IFID_rs1  in  REG_W  source 1 of instruction in ID
IFID_rs2  in  REG_W  source 2 of instruction in ID
IFID_rs1_used  in  1  ID instruction reads rs1
IFID_rs2_used  in  1  ID instruction reads rs2
branch_taken  in  1  EX resolved a taken branch/jump
PCWrite  out  1  1 = PC updates
IFID_Write  out  1  1 = IF/ID register loads
IFID_Flush  out  1  1 = IF/ID cleared to NOP
IDEX_Write  out  1  1 = ID/EX register loads
IDEX_mux_out  out  1  1 = pass ID controls, 0 = insert bubble
EXMEM_mux_out  out  1  1 = pass EX controls, 0 = insert bubble
busy  out  1  FSM not in IDLE
stall_count  out  CNT_W  cycles with PCWrite=0

Behaviour:
- Default ("pass") outputs: PCWrite=1, IFID_Write=1, IDEX_Write=1, IDEX_mux_out=1, EXMEM_mux_out=1, IFID_Flush=0.
- All outputs except stall_count are combinational from state and inputs.
- hit = IDEX_MemRead & (IDEX_rd!=0 | !IGNORE_X0) & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
- Load stall outputs: PCWrite=0, IFID_Write=0, IDEX_mux_out=0; all others pass.
- Mul/div stall outputs: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_mux_out=0; IDEX_mux_out=1.
- Reset while asserted: state←IDLE, cnt←0, stall_count←0; outputs forced to pass values regardless of inputs. Reset mid-stall aborts the stall immediately.
- Priority in IDLE: branch_taken > IDEX_MulDiv > hit.
- IDLE, branch_taken:
  - IFID_Flush=1, IDEX_mux_out=0, PCWrite=1, IFID_Write=1.
  - Stay IDLE.
- IDLE, IDEX_MulDiv:
  - Drive mul/div stall outputs.
  - cnt←MULDIV_CYCLES-2; go MD_BUSY.
- IDLE, hit:
  - Drive load stall outputs.
  - If LOAD_LATENCY==1, stay IDLE; the bubble now in EX clears the hit.
  - Otherwise cnt←LOAD_LATENCY-2; go LOAD_STALL.
- LOAD_STALL:
  - Drive load stall outputs.
  - If cnt==0 go IDLE, else cnt←cnt-1.
  - Total load-use stall = LOAD_LATENCY cycles.
  - branch_taken and hit are ignored here because EX holds a bubble.
- MD_BUSY:
  - If cnt!=0: drive mul/div stall outputs, cnt←cnt-1.
  - If cnt==0: drive pass outputs so EX advances, go IDLE.
  - Total front-end stall = MULDIV_CYCLES-1 cycles; mul/div occupies EX for MULDIV_CYCLES cycles.
  - IDEX_MulDiv, hit and branch_taken are ignored in MD_BUSY.
  - A hit against the completing mul/div (ALU result) needs no stall; only MemRead produces hit.
- busy = (state != IDLE).
- stall_count:
  - Increments by 1 every cycle PCWrite==0 (reset cycles excluded).
  - Saturates at 2^CNT_W-1 with no wrap.
- cnt width = clog2(max(LOAD_LATENCY, MULDIV_CYCLES)), minimum 1.

Test Plan:
- Defaults: lw x5 in EX, ID reads rs1=x5 (rs1_used=1) → one cycle with PCWrite=IFID_Write=IDEX_mux_out=0, busy=0, stall_count=1; next cycle all pass.
- LOAD_LATENCY=3: load-use on rs2=x7 → PCWrite=0 for exactly 3 cycles, busy=1 in cycles 2–3, stall_count=3; rs2_used=0 or rd=x0 → no stall, stall_count=0.
- MULDIV_CYCLES=4: IDEX_MulDiv held high → PCWrite=IDEX_Write=EXMEM_mux_out=0 for 3 cycles, 4th cycle pass, FSM IDLE, stall_count=3.
- branch_taken=1 with a simultaneous load-use hit in IDLE → IFID_Flush=1, IDEX_mux_out=0, PCWrite=1, no stall, stall_count unchanged.
- MULDIV_CYCLES=8: assert reset for 1 cycle at stall cycle 3 → next cycle pass outputs, busy=0, stall_count=0.
- CNT_W=2: five consecutive load-use stalls → stall_count sticks at 3.
